// File: rtl/vga_pattern_source.sv
// rtl/vga_pattern_source.sv - raster-order RGB test pattern writer feeding the VGA pixel FIFO
module vga_pattern_source #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int CHECK_LOG2 = 5,
    parameter int BAR_W      = 80
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic [23:0] solid_color,
    input  logic        fifo_full,
    output logic        fifo_wreq,
    output logic [23:0] fifo_wdata,
    output logic        frame_done,
    output logic        busy
);
    localparam int XW = $clog2(H_ACTIVE);
    localparam int YW = $clog2(V_ACTIVE);
    localparam int CW = $clog2(BAR_W);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [CW-1:0] bar_cnt_q, bar_cnt_d;
    logic [2:0]    bar_idx_q, bar_idx_d;
    logic [1:0]    mode_q, mode_d;
    logic [23:0]   color_q, color_d;
    logic          frame_done_q, frame_done_d;

    logic x_last, y_last, bar_last;
    logic [7:0] x_lo, y_lo;

    assign x_last   = (x_q == XW'(H_ACTIVE - 1));
    assign y_last   = (y_q == YW'(V_ACTIVE - 1));
    assign bar_last = (bar_cnt_q == CW'(BAR_W - 1));

    assign busy       = (state_q == RUN);
    assign fifo_wreq  = (state_q == RUN) && !fifo_full;
    assign frame_done = frame_done_q;

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        bar_cnt_d    = bar_cnt_q;
        bar_idx_d    = bar_idx_q;
        mode_d       = mode_q;
        color_d      = color_q;
        frame_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d   = RUN;
                    mode_d    = mode;
                    color_d   = solid_color;
                    x_d       = '0;
                    y_d       = '0;
                    bar_cnt_d = '0;
                    bar_idx_d = '0;
                end
            end
            RUN: begin
                if (fifo_wreq) begin
                    if (x_last) begin
                        x_d       = '0;
                        bar_cnt_d = '0;
                        bar_idx_d = '0;
                        if (y_last) begin
                            y_d          = '0;
                            frame_done_d = 1'b1;
                            // Pattern settings only change on a frame boundary.
                            if (enable) begin
                                mode_d  = mode;
                                color_d = solid_color;
                            end else begin
                                state_d = IDLE;
                            end
                        end else begin
                            y_d = y_q + 1'b1;
                        end
                    end else begin
                        x_d = x_q + 1'b1;
                        if (bar_last) begin
                            bar_cnt_d = '0;
                            bar_idx_d = bar_idx_q + 3'd1;
                        end else begin
                            bar_cnt_d = bar_cnt_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            bar_cnt_q    <= '0;
            bar_idx_q    <= '0;
            mode_q       <= '0;
            color_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            bar_cnt_q    <= bar_cnt_d;
            bar_idx_q    <= bar_idx_d;
            mode_q       <= mode_d;
            color_q      <= color_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign x_lo = 8'(x_q);
    assign y_lo = 8'(y_q);

    always_comb begin
        fifo_wdata = 24'h000000;
        if (state_q == RUN) begin
            case (mode_q)
                2'd0: fifo_wdata = color_q;
                2'd1: begin
                    case (bar_idx_q)
                        3'd0:    fifo_wdata = 24'hFFFFFF;
                        3'd1:    fifo_wdata = 24'hFFFF00;
                        3'd2:    fifo_wdata = 24'h00FFFF;
                        3'd3:    fifo_wdata = 24'h00FF00;
                        3'd4:    fifo_wdata = 24'hFF00FF;
                        3'd5:    fifo_wdata = 24'hFF0000;
                        3'd6:    fifo_wdata = 24'h0000FF;
                        default: fifo_wdata = 24'h000000;
                    endcase
                end
                2'd2: fifo_wdata = (x_q[CHECK_LOG2] ^ y_q[CHECK_LOG2]) ? 24'hFFFFFF : 24'h000000;
                default: fifo_wdata = {x_lo, y_lo, x_lo ^ y_lo};
            endcase
        end
    end
endmodule

// File: tb/tb_vga_pattern_source.sv
// tb/tb_vga_pattern_source.sv - randomized bench for vga_pattern_source against a pixel-index reference model
module tb_vga_pattern_source;
    localparam int H  = 160;
    localparam int V  = 40;
    localparam int BW = 20;
    localparam int CL = 5;
    localparam int NPIX = H * V;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [1:0]  mode;
    logic [23:0] solid_color;
    logic        fifo_full;
    logic        fifo_wreq;
    logic [23:0] fifo_wdata;
    logic        frame_done;
    logic        busy;

    vga_pattern_source #(.H_ACTIVE(H), .V_ACTIVE(V), .CHECK_LOG2(CL), .BAR_W(BW)) dut (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .solid_color(solid_color),
        .fifo_full(fifo_full), .fifo_wreq(fifo_wreq), .fifo_wdata(fifo_wdata),
        .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state: frame progress as a linear pixel index
    bit          running;
    logic [1:0]  m_mode;
    logic [23:0] m_color;
    int          pix;
    bit          exp_fd;
    int          m_frames;
    int          dut_writes;
    int          dut_frames;
    int          stall_left;
    bit          rand_stall;
    int          guard;

    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h (pix=%0d t=%0t)", tag, got, exp, pix, $time);
        end
    endtask

    function automatic logic [23:0] exp_pix(input logic [1:0] m, input logic [23:0] c, input int p);
        int x, y;
        logic [7:0] xb, yb;
        x  = p % H;
        y  = p / H;
        xb = x[7:0];
        yb = y[7:0];
        case (m)
            2'd0:    return c;
            2'd1:    return bars[x / BW];
            2'd2:    return ((((x >> CL) ^ (y >> CL)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
            default: return {xb, yb, xb ^ yb};
        endcase
    endfunction

    task automatic model_reset();
        running    = 0;
        m_mode     = 0;
        m_color    = 0;
        pix        = 0;
        exp_fd     = 0;
        dut_writes = 0;
    endtask

    task automatic tick();
        #1;
        chk("busy", busy, running);
        chk("wreq", fifo_wreq, running && !fifo_full);
        chk("wdata", fifo_wdata, running ? exp_pix(m_mode, m_color, pix) : 24'h0);
        chk("frame_done", frame_done, exp_fd);
        if (frame_done) begin
            chk("frame_writes", dut_writes, NPIX);
            dut_writes = 0;
            dut_frames++;
        end
        if (fifo_wreq) dut_writes++;
        exp_fd = 0;
        if (!running) begin
            if (enable) begin
                running = 1;
                m_mode  = mode;
                m_color = solid_color;
                pix     = 0;
            end
        end else if (!fifo_full) begin
            if (pix == NPIX - 1) begin
                exp_fd = 1;
                m_frames++;
                pix = 0;
                if (enable) begin
                    m_mode  = mode;
                    m_color = solid_color;
                end else begin
                    running = 0;
                end
            end else begin
                pix++;
            end
        end
        @(negedge clk);
    endtask

    task automatic step();
        if (stall_left > 0) begin
            fifo_full = 1'b1;
            stall_left--;
        end else begin
            fifo_full = rand_stall && ($urandom_range(0, 7) == 0);
        end
        tick();
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; mode = 2'd0; solid_color = 24'h0; fifo_full = 1'b0;
        m_frames = 0; dut_frames = 0; stall_left = 0; rand_stall = 0;
        model_reset();
        @(negedge clk);
        repeat (2) tick();
        rst = 1'b0;
        repeat (3) tick();

        // frame 1: solid, no stalls; request bars mid-frame for the next frame
        enable = 1'b1; mode = 2'd0; solid_color = 24'h123456;
        guard = 0;
        while (m_frames < 1 && guard < 3 * NPIX) begin
            if (running && pix == H * 10) begin
                mode = 2'd1;
                solid_color = 24'($urandom);
            end
            step();
            guard++;
        end
        chk("frame1_reached", m_frames, 1);

        // frame 2: colour bars with random stalls
        rand_stall = 1;
        guard = 0;
        while (m_frames < 2 && guard < 3 * NPIX) begin
            if (running && pix == H * 10) mode = 2'd2;
            step();
            guard++;
        end
        chk("frame2_reached", m_frames, 2);

        // frame 3: checkerboard; drop enable mid-frame
        guard = 0;
        while (m_frames < 3 && guard < 3 * NPIX) begin
            if (running && pix == H * 5) begin
                mode   = 2'd3;
                enable = 1'b0;
            end
            step();
            guard++;
        end
        chk("frame3_reached", m_frames, 3);
        repeat (5) step();
        chk("idle_busy", busy, 1'b0);
        chk("dut_frames", dut_frames, 3);

        // frame 4: gradient, directed stall at (H-1,0), async reset at (100,20)
        enable = 1'b1; mode = 2'd3;
        guard = 0;
        while (!(running && pix == 20 * H + 100) && guard < 3 * NPIX) begin
            if (running && pix == H - 1 && stall_left == 0 && guard < 2 * H) stall_left = 10;
            step();
            guard++;
        end
        chk("reset_point_reached", (running && pix == 20 * H + 100), 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("rst_wreq", fifo_wreq, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_wdata", fifo_wdata, 24'h0);
        chk("rst_frame_done", frame_done, 1'b0);
        model_reset();
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) step();

        // restart must begin again at (0,0)
        enable = 1'b1; mode = 2'd3; solid_color = 24'($urandom);
        guard = 0;
        while (!(running && pix == 3 * H) && guard < 3 * NPIX) begin
            step();
            guard++;
        end
        chk("restart_progress", (running && pix == 3 * H), 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
